// File: rtl/pong_pkg.sv
// Shared phase encoding, sensor code constants and helpers for the pong match controller.
// Optional feature macro used by the design files: PADDLE_REPEAT_EN.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } phase_t;

  localparam logic [2:0] SENS_DN  = 3'b100;
  localparam logic [2:0] SENS_MID = 3'b010;
  localparam logic [2:0] SENS_UP  = 3'b001;

  // Only the three one-hot codes are meaningful; anything else is sensor noise.
  function automatic logic is_valid_code(input logic [2:0] code);
    return (code == SENS_DN) || (code == SENS_MID) || (code == SENS_UP);
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Player/ball-side signal bundle of the pong match controller.
// master drives sensors, misses and start; slave is the controller itself.
interface pong_match_ctrl_if #(
  parameter int POS_W   = 3,
  parameter int SCORE_W = 4
);

  logic               start;
  logic [2:0]         sens_l;
  logic [2:0]         sens_r;
  logic               miss_l;
  logic               miss_r;
  logic [POS_W-1:0]   paddle_l;
  logic [POS_W-1:0]   paddle_r;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic [2:0]         phase;
  logic               serve_pulse;

  modport master (
    output start, sens_l, sens_r, miss_l, miss_r,
    input  paddle_l, paddle_r, score_l, score_r, phase, serve_pulse
  );

  modport slave (
    input  start, sens_l, sens_r, miss_l, miss_r,
    output paddle_l, paddle_r, score_l, score_r, phase, serve_pulse
  );

endinterface

// File: rtl/pong_match_ctrl_paddle_gesture.sv
// Turns one player's 3-bit sensor sweep into registered up/down step pulses.
// With PADDLE_REPEAT_EN defined, holding an outer code in PLAY auto-repeats a step.
module paddle_gesture
  import pong_pkg::*;
`ifdef PADDLE_REPEAT_EN
#(
  parameter int REPEAT_CYCLES = 12_500_000
)
`endif
(
  input  logic       clk,
  input  logic       rst,
`ifdef PADDLE_REPEAT_EN
  input  logic       play,
`endif
  input  logic [2:0] sens,
  output logic       step_up,
  output logic       step_dn
);

  logic [2:0] prev;
  logic       rep_up;
  logic       rep_dn;

`ifdef PADDLE_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_CYCLES + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_next;
  logic [CNT_W-1:0] hold_run;

  // hold_run counts consecutive cycles of the same outer code, including this one.
  always_comb begin
    hold_next = '0;
    hold_run  = '0;
    rep_up    = 1'b0;
    rep_dn    = 1'b0;
    if (play && ((sens == SENS_DN) || (sens == SENS_UP))) begin
      hold_run = (sens == prev) ? hold_cnt + CNT_W'(1) : CNT_W'(1);
      if (hold_run == CNT_W'(REPEAT_CYCLES)) begin
        rep_dn = (sens == SENS_DN);
        rep_up = (sens == SENS_UP);
      end else begin
        hold_next = hold_run;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_next;
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  // A step is a return to the middle sensor from one of the outer ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= SENS_MID;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      step_dn <= ((sens == SENS_MID) && (prev == SENS_DN)) || rep_dn;
      step_up <= ((sens == SENS_MID) && (prev == SENS_UP)) || rep_up;
      if (is_valid_code(sens)) prev <= sens;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: phase FSM, serve timer, paddle positions and scores.
// Define PADDLE_REPEAT_EN to enable hold-to-repeat paddle steps.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int POS_W        = 3,
  parameter int POS_MAX      = 6,
  parameter int POS_START    = 3,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_CYCLES = 25_000_000
`ifdef PADDLE_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 12_500_000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  pong_match_ctrl_if.slave   bus
);

  localparam int SRV_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [POS_W-1:0]   P_MAX    = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]   P_START  = POS_W'(POS_START);
  localparam logic [SCORE_W-1:0] S_WIN    = SCORE_W'(WIN_SCORE);
  localparam logic [SRV_W-1:0]   SRV_LAST = SRV_W'(SERVE_CYCLES - 1);

  phase_t             state;
  phase_t             state_next;
  logic [SRV_W-1:0]   serve_cnt;
  logic [POS_W-1:0]   paddle_l;
  logic [POS_W-1:0]   paddle_r;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               serve_pulse;
  logic               up_l, dn_l, up_r, dn_r;
  logic               in_play;
  logic               serve_done;
  logic               match_won;

  assign in_play    = (state == PLAY);
  assign serve_done = (state == SERVE) && (serve_cnt == SRV_LAST);
  assign match_won  = (score_l == S_WIN) || (score_r == S_WIN);

  paddle_gesture
`ifdef PADDLE_REPEAT_EN
    #(.REPEAT_CYCLES(REPEAT_CYCLES))
`endif
    u_gesture_l (
      .clk     (clk),
      .rst     (rst),
`ifdef PADDLE_REPEAT_EN
      .play    (in_play),
`endif
      .sens    (bus.sens_l),
      .step_up (up_l),
      .step_dn (dn_l)
    );

  paddle_gesture
`ifdef PADDLE_REPEAT_EN
    #(.REPEAT_CYCLES(REPEAT_CYCLES))
`endif
    u_gesture_r (
      .clk     (clk),
      .rst     (rst),
`ifdef PADDLE_REPEAT_EN
      .play    (in_play),
`endif
      .sens    (bus.sens_r),
      .step_up (up_r),
      .step_dn (dn_r)
    );

  function automatic logic [POS_W-1:0] move(input logic [POS_W-1:0] pos,
                                            input logic up, input logic dn);
    if (dn && (pos != '0))    return pos - POS_W'(1);
    if (up && (pos != P_MAX)) return pos + POS_W'(1);
    return pos;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SERVE;
      SERVE:   if (serve_done) state_next = PLAY;
      PLAY:    if (bus.miss_l || bus.miss_r) state_next = POINT;
      POINT:   state_next = match_won ? OVER : SERVE;
      OVER:    if (bus.start) state_next = SERVE;
      default: state_next = IDLE;
    endcase
  end

  // Simultaneous misses are a wash: the rally ends but nobody scores.
  always_ff @(posedge clk) begin
    if (rst) begin
      serve_cnt   <= '0;
      paddle_l    <= P_START;
      paddle_r    <= P_START;
      score_l     <= '0;
      score_r     <= '0;
      serve_pulse <= 1'b0;
    end else begin
      serve_pulse <= serve_done;
      serve_cnt   <= ((state == SERVE) && !serve_done) ? serve_cnt + SRV_W'(1) : '0;
      case (state)
        IDLE: begin
          paddle_l <= P_START;
          paddle_r <= P_START;
          score_l  <= '0;
          score_r  <= '0;
        end
        SERVE: begin
          paddle_l <= P_START;
          paddle_r <= P_START;
        end
        PLAY: begin
          paddle_l <= move(paddle_l, up_l, dn_l);
          paddle_r <= move(paddle_r, up_r, dn_r);
          if (bus.miss_l && !bus.miss_r && (score_r != S_WIN)) score_r <= score_r + SCORE_W'(1);
          if (bus.miss_r && !bus.miss_l && (score_l != S_WIN)) score_l <= score_l + SCORE_W'(1);
        end
        OVER: begin
          if (bus.start) begin
            score_l <= '0;
            score_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.paddle_l    = paddle_l;
  assign bus.paddle_r    = paddle_r;
  assign bus.score_l     = score_l;
  assign bus.score_r     = score_r;
  assign bus.phase       = state;
  assign bus.serve_pulse = serve_pulse;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed match scenarios plus random play
// compared every cycle against a behavioural match model.
module tb_pong_match_ctrl;
  import pong_pkg::*;

  localparam int SERVE_N = 4;
  localparam int WIN_N   = 2;
  localparam int PMAX_N  = 6;
  localparam int PSTRT_N = 3;
`ifdef PADDLE_REPEAT_EN
  localparam int REPEAT_N = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pong_match_ctrl_if #(.POS_W(3), .SCORE_W(4)) bus();

  pong_match_ctrl #(
    .POS_W(3), .POS_MAX(PMAX_N), .POS_START(PSTRT_N), .SCORE_W(4),
    .WIN_SCORE(WIN_N), .SERVE_CYCLES(SERVE_N)
`ifdef PADDLE_REPEAT_EN
    , .REPEAT_CYCLES(REPEAT_N)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural model state: phase, paddles, scores, serve timer and per-player gesture memory.
  phase_t m_phase;
  int m_pl, m_pr, m_sl, m_sr, m_sp, m_srv;
  int m_prev_l, m_prev_r;
  int m_up_l, m_dn_l, m_up_r, m_dn_r;
  int m_hold_l, m_hold_r;
  logic [2:0] m_last_l, m_last_r;
  logic [2:0] cur_sl = SENS_MID;
  logic [2:0] cur_sr = SENS_MID;

  function automatic int lane(input logic [2:0] c);
    case (c)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > PMAX_N) return PMAX_N;
    return v;
  endfunction

  task automatic sensorStep(input logic [2:0] code, input bit playing, inout int prev,
                            inout int hold, inout logic [2:0] last, output int up, output int dn);
    int ln;
    ln = lane(code);
    up = 0;
    dn = 0;
    if (ln == 1 && prev == 0) dn = 1;
    if (ln == 1 && prev == 2) up = 1;
    if (ln >= 0) prev = ln;
`ifdef PADDLE_REPEAT_EN
    if (playing && (ln == 0 || ln == 2)) begin
      hold = (code == last) ? hold + 1 : 1;
      if (hold == REPEAT_N) begin
        hold = 0;
        if (ln == 0) dn = 1;
        else         up = 1;
      end
    end else begin
      hold = 0;
    end
`else
    hold = playing ? 0 : 0;
`endif
    last = code;
  endtask

  task automatic modelEdge(input logic r, input logic st, input logic [2:0] sl_in,
                           input logic [2:0] sr_in, input logic ml, input logic mr);
    phase_t ph;
    ph = m_phase;
    if (r) begin
      m_phase = IDLE;
      m_pl = PSTRT_N; m_pr = PSTRT_N; m_sl = 0; m_sr = 0; m_sp = 0; m_srv = 0;
      m_prev_l = 1; m_prev_r = 1;
      m_up_l = 0; m_dn_l = 0; m_up_r = 0; m_dn_r = 0;
      m_hold_l = 0; m_hold_r = 0; m_last_l = SENS_MID; m_last_r = SENS_MID;
      return;
    end
    m_sp = 0;
    case (ph)
      IDLE: begin
        m_pl = PSTRT_N; m_pr = PSTRT_N; m_sl = 0; m_sr = 0; m_srv = 0;
        if (st) m_phase = SERVE;
      end
      SERVE: begin
        m_pl = PSTRT_N; m_pr = PSTRT_N;
        if (m_srv == SERVE_N - 1) begin
          m_phase = PLAY; m_sp = 1; m_srv = 0;
        end else begin
          m_srv++;
        end
      end
      PLAY: begin
        m_pl = clamp(m_pl + m_up_l - m_dn_l);
        m_pr = clamp(m_pr + m_up_r - m_dn_r);
        if (ml && !mr && m_sr < WIN_N) m_sr++;
        if (mr && !ml && m_sl < WIN_N) m_sl++;
        if (ml || mr) m_phase = POINT;
      end
      POINT: m_phase = (m_sl == WIN_N || m_sr == WIN_N) ? OVER : SERVE;
      OVER: begin
        if (st) begin
          m_sl = 0; m_sr = 0; m_phase = SERVE;
        end
      end
      default: m_phase = IDLE;
    endcase
    sensorStep(sl_in, ph == PLAY, m_prev_l, m_hold_l, m_last_l, m_up_l, m_dn_l);
    sensorStep(sr_in, ph == PLAY, m_prev_r, m_hold_r, m_last_r, m_up_r, m_dn_r);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic [2:0] sl_in,
                               input logic [2:0] sr_in, input logic ml, input logic mr);
    @(negedge clk);
    rst = r;
    bus.start  = st;
    bus.sens_l = sl_in;
    bus.sens_r = sr_in;
    bus.miss_l = ml;
    bus.miss_r = mr;
    cur_sl = sl_in;
    cur_sr = sr_in;
    @(posedge clk);
    modelEdge(r, st, sl_in, sr_in, ml, mr);
    #1;
    checkOutput("phase",       32'(bus.phase),       32'(m_phase));
    checkOutput("paddle_l",    32'(bus.paddle_l),    32'(m_pl));
    checkOutput("paddle_r",    32'(bus.paddle_r),    32'(m_pr));
    checkOutput("score_l",     32'(bus.score_l),     32'(m_sl));
    checkOutput("score_r",     32'(bus.score_r),     32'(m_sr));
    checkOutput("serve_pulse", 32'(bus.serve_pulse), 32'(m_sp));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, cur_sl, cur_sr, 1'b0, 1'b0);
  endtask

  task automatic sweepL(input logic [2:0] outer, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, outer, cur_sr, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, SENS_MID, cur_sr, 1'b0, 1'b0);
    end
  endtask

  task automatic sweepR(input logic [2:0] outer, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, cur_sl, outer, 1'b0, 1'b0);
      if (i == 2) applyStimulus(1'b0, 1'b0, cur_sl, 3'b011, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, cur_sl, SENS_MID, 1'b0, 1'b0);
    end
  endtask

  logic [2:0] rnd_l, rnd_r;

  function automatic logic [2:0] randCode(input logic [2:0] held);
    case ($urandom_range(0, 7))
      0, 1:    return SENS_DN;
      2, 3:    return SENS_MID;
      4, 5:    return SENS_UP;
      6:       return 3'($urandom_range(0, 7));
      default: return held;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.sens_l = SENS_MID; bus.sens_r = SENS_MID;
    bus.miss_l = 1'b0; bus.miss_r = 1'b0;
    applyStimulus(1'b1, 1'b0, SENS_MID, SENS_MID, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, SENS_MID, SENS_MID, 1'b0, 1'b0);
    idleCycles(2);

    // Match start, serve countdown, then sweeps driving both paddles into their limits.
    applyStimulus(1'b0, 1'b1, SENS_MID, SENS_MID, 1'b0, 1'b0);
    idleCycles(SERVE_N + 1);
    sweepL(SENS_DN, 4);
    idleCycles(2);
    sweepR(SENS_UP, 5);
    idleCycles(2);

    // Right player misses twice: left wins, then a late miss in OVER is ignored.
    applyStimulus(1'b0, 1'b0, cur_sl, cur_sr, 1'b0, 1'b1);
    idleCycles(SERVE_N + 2);
    applyStimulus(1'b0, 1'b0, cur_sl, cur_sr, 1'b0, 1'b1);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, cur_sl, cur_sr, 1'b1, 1'b0);
    idleCycles(2);

    // Rematch, simultaneous misses, then reset mid-rally with paddle_l=1 and score_r=1.
    applyStimulus(1'b0, 1'b1, cur_sl, cur_sr, 1'b0, 1'b0);
    idleCycles(SERVE_N + 1);
    applyStimulus(1'b0, 1'b0, cur_sl, cur_sr, 1'b1, 1'b1);
    idleCycles(SERVE_N + 2);
    applyStimulus(1'b0, 1'b0, cur_sl, cur_sr, 1'b1, 1'b0);
    idleCycles(SERVE_N + 2);
    sweepL(SENS_DN, 2);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, cur_sl, cur_sr, 1'b0, 1'b0);
    idleCycles(2);

    // Random play with occasional restarts and resets.
    applyStimulus(1'b0, 1'b1, cur_sl, cur_sr, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      rnd_l = randCode(cur_sl);
      rnd_r = randCode(cur_sr);
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, rnd_l, rnd_r,
                    $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
